// File: rtl/winograd_pkg.sv
// Shared constants and state encoding for the
// Winograd reverse-transform datapath.
package winograd_pkg;

    localparam int DATA_W = 40;
    localparam int M_DIM  = 6;
    localparam int R_DIM  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or
// after ptr, wrapping; purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               any_req
);

    // scan from ptr upward so the pointer holder has top priority
    always_comb begin
        logic found;
        int   idx;
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtu_arbiter.sv
// Shares one reverse transform unit among NUM_REQ
// requesters with round-robin grant and a watchdog.
module rtu_arbiter
    import winograd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = winograd_pkg::DATA_W,
    parameter int TIMEOUT = 32,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ*M_DIM*M_DIM*DATA_W-1:0]   m_tile,
    output logic [NUM_REQ-1:0]                      ack,
    output logic [R_DIM*R_DIM*DATA_W-1:0]           r_tile,
    output logic                                    r_valid,
    output logic [IW-1:0]                           r_id,
    input  logic                                    r_ready,
    output logic                                    rtu_start,
    output logic [M_DIM*M_DIM*DATA_W-1:0]           rtu_m,
    input  logic [R_DIM*R_DIM*DATA_W-1:0]           rtu_r,
    input  logic                                    rtu_done,
    input  logic                                    rtu_busy,
    output logic                                    err_timeout
);

    localparam int MW = M_DIM * M_DIM * DATA_W;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_e          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt;
    logic            any_req;
    logic [MW-1:0]   m_buf;
    logic [WW-1:0]   wdog;

    assign rtu_m = m_buf;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant   (gnt),
        .any_req (any_req)
    );

    // grant / run / hold-result sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            ack         <= '0;
            rtu_start   <= 1'b0;
            r_valid     <= 1'b0;
            r_id        <= '0;
            r_tile      <= '0;
            m_buf       <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            ack <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req && !rtu_done && !rtu_busy) begin
                        m_buf     <= m_tile[int'(gnt)*MW +: MW];
                        r_id      <= gnt;
                        ack[gnt]  <= 1'b1;
                        rtu_start <= 1'b1;
                        wdog      <= '0;
                        ptr       <= (gnt == IW'(NUM_REQ - 1))
                                     ? '0 : gnt + 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rtu_done) begin
                        r_tile    <= rtu_r;
                        rtu_start <= 1'b0;
                        r_valid   <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        rtu_start   <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtu_arbiter.sv
// Directed and random checks of rtu_arbiter against a
// transaction-level round-robin model and a stub RTU.
module tb_rtu_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 40;
    localparam int MW  = 36 * DW;
    localparam int RW  = 16 * DW;
    localparam int LAT = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*MW-1:0] m_tile;
    logic [NR-1:0]   ack;
    logic [RW-1:0]   r_tile;
    logic            r_valid;
    logic [1:0]      r_id;
    logic            r_ready;
    logic            rtu_start;
    logic [MW-1:0]   rtu_m;
    logic [RW-1:0]   rtu_r;
    logic            rtu_done;
    logic            rtu_busy;
    logic            err_timeout;
    logic            hang;
    int              cnt;

    int checks = 0;
    int errors = 0;

    int            ptr_m = 0;
    int            grants = 0;
    logic [RW-1:0] exp_q[$];
    int            id_q[$];

    rtu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .m_tile      (m_tile),
        .ack         (ack),
        .r_tile      (r_tile),
        .r_valid     (r_valid),
        .r_id        (r_id),
        .r_ready     (r_ready),
        .rtu_start   (rtu_start),
        .rtu_m       (rtu_m),
        .rtu_r       (rtu_r),
        .rtu_done    (rtu_done),
        .rtu_busy    (rtu_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // stub transform: r[i][j] = m[i][j] + m[i+2][j+2]
    function automatic logic [RW-1:0] xform(input logic [MW-1:0] m);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[(i*4+j)*DW +: DW] = m[(i*6+j)*DW +: DW]
                                    + m[((i+2)*6+j+2)*DW +: DW];
        return r;
    endfunction

    always_comb rtu_r = xform(rtu_m);
    assign rtu_busy = rtu_start && !rtu_done;

    // stub RTU: done after LAT cycles of start, held until start drops
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 0;
            rtu_done <= 1'b0;
        end else if (!rtu_start) begin
            cnt      <= 0;
            rtu_done <= 1'b0;
        end else if (!rtu_done && !hang) begin
            if (cnt == LAT - 1) rtu_done <= 1'b1;
            cnt <= cnt + 1;
        end
    end

    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++)
            if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic logic [MW-1:0] rnd_tile();
        logic [MW-1:0] t;
        for (int e = 0; e < 36; e++)
            t[e*DW +: DW] = DW'({$urandom(), $urandom()});
        return t;
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one cycle: model the edge, then check outputs at negedge
    task automatic step();
        logic [NR-1:0]    req_s;
        logic [NR*MW-1:0] m_s;
        logic             acc_s;
        logic             err_s;
        int               pick;
        req_s = req;
        m_s   = m_tile;
        acc_s = r_valid && r_ready && !rst;
        err_s = err_timeout;
        @(negedge clk);
        if (acc_s && id_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
        end
        if (err_timeout && !err_s && id_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
        end
        if (ack !== '0) begin
            pick = rr_pick(req_s, ptr_m);
            chk("ack_grant", RW'(ack),
                (pick < 0) ? '0 : RW'(1) << pick);
            if (pick >= 0) begin
                exp_q.push_back(xform(m_s[pick*MW +: MW]));
                id_q.push_back(pick);
                ptr_m = (pick + 1) % NR;
                grants++;
            end
        end
        if (r_valid === 1'b1) begin
            if (id_q.size() == 0) begin
                chk("r_valid_spurious", RW'(r_valid), '0);
            end else begin
                chk("r_id", RW'(r_id), RW'(id_q[0]));
                chk("r_tile", r_tile, exp_q[0]);
            end
        end
    endtask

    task automatic wait_for(input string tag, input int sel,
                            input int bound, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < bound) begin
            step();
            n++;
            case (sel)
                0:       hit = (ack !== '0);
                1:       hit = (r_valid === 1'b1);
                default: hit = (err_timeout === 1'b1);
            endcase
        end
        if (!hit) chk({tag, "_expired"}, '0, RW'(1));
    endtask

    initial begin
        int            n;
        logic [MW-1:0] t;
        logic [MW-1:0] ta;
        rst     = 1'b1;
        req     = '0;
        m_tile  = '0;
        r_ready = 1'b0;
        hang    = 1'b0;
        repeat (2) step();

        // reset state
        chk("rst_ack", RW'(ack), '0);
        chk("rst_r_valid", RW'(r_valid), '0);
        chk("rst_rtu_start", RW'(rtu_start), '0);
        chk("rst_r_id", RW'(r_id), '0);
        chk("rst_r_tile", r_tile, '0);
        chk("rst_rtu_m", RW'(rtu_m), '0);
        chk("rst_err", RW'(err_timeout), '0);
        rst = 1'b0;

        // all four requesting: 0,1,2,3,0 at 14-cycle spacing
        for (int k = 0; k < NR; k++) m_tile[k*MW +: MW] = rnd_tile();
        req     = '1;
        r_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_for("t2_ack", 0, 40, n);
            chk("t2_order", RW'(ack), RW'(1) << (g % NR));
            chk("t2_spacing", RW'(n), RW'((g == 0) ? 1 : 14));
        end
        req = '0;
        repeat (16) step();

        // single req[2] with M[0][0]=5
        t = '0;
        t[DW-1:0] = DW'(5);
        m_tile[2*MW +: MW] = t;
        req     = 4'b0100;
        r_ready = 1'b0;
        wait_for("t1_ack", 0, 40, n);
        chk("t1_ack_lat", RW'(n), RW'(1));
        chk("t1_ack", RW'(ack), RW'(4'b0100));
        req = 4'b1011;
        wait_for("t1_rv", 1, 40, n);
        chk("t1_rv_lat", RW'(n), RW'(12));
        chk("t1_tile", r_tile, RW'(5));
        chk("t1_id", RW'(r_id), RW'(2));

        // consumer stalls 20 cycles while others request
        for (int c = 0; c < 20; c++) begin
            step();
            chk("stall_no_ack", RW'(ack), '0);
            chk("stall_start", RW'(rtu_start), '0);
            chk("stall_valid", RW'(r_valid), RW'(1));
        end
        req     = '0;
        r_ready = 1'b1;
        repeat (4) step();

        // m_tile changed right after ack must not matter
        ta = rnd_tile();
        m_tile[0 +: MW] = ta;
        req = 4'b0001;
        wait_for("t5_ack", 0, 40, n);
        m_tile[0 +: MW] = rnd_tile();
        req = '0;
        wait_for("t5_rv", 1, 40, n);
        chk("t5_tile", r_tile, xform(ta));
        repeat (3) step();

        // RTU never finishes: watchdog fires at run cycle 32
        hang = 1'b1;
        req  = 4'b0010;
        wait_for("t3_ack", 0, 40, n);
        req = '0;
        wait_for("t3_err", 2, 60, n);
        chk("t3_err_lat", RW'(n), RW'(32));
        chk("t3_start", RW'(rtu_start), '0);
        hang = 1'b0;
        req  = 4'b0100;
        wait_for("t3_next", 0, 10, n);
        chk("t3_next_lat", RW'(n), RW'(1));
        chk("t3_next_ack", RW'(ack), RW'(4'b0100));
        req = '0;
        wait_for("t3_rv", 1, 40, n);
        repeat (3) step();
        chk("t3_err_sticky", RW'(err_timeout), RW'(1));

        // reset in the middle of a run
        req = 4'b0010;
        wait_for("t4_ack", 0, 40, n);
        req = '0;
        repeat (4) step();
        #1 rst = 1'b1;
        #1;
        chk("t4_start", RW'(rtu_start), '0);
        chk("t4_valid", RW'(r_valid), '0);
        chk("t4_r_tile", r_tile, '0);
        chk("t4_r_id", RW'(r_id), '0);
        chk("t4_rtu_m", RW'(rtu_m), '0);
        chk("t4_err", RW'(err_timeout), '0);
        exp_q.delete();
        id_q.delete();
        ptr_m = 0;
        req = 4'b1010;
        repeat (2) step();
        rst = 1'b0;
        wait_for("t4_ack2", 0, 10, n);
        chk("t4_prio", RW'(ack), RW'(4'b0010));
        req = '0;
        wait_for("t4_rv", 1, 40, n);
        repeat (3) step();

        // random traffic against the model
        grants = 0;
        for (int c = 0; c < 600; c++) begin
            req     = NR'($urandom);
            r_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1)
                m_tile[$urandom_range(NR-1)*MW +: MW] = rnd_tile();
            step();
        end
        req     = '0;
        r_ready = 1'b1;
        repeat (40) step();
        chk("rand_drain", RW'(id_q.size()), '0);
        chk("rand_grants", RW'(grants > 10), RW'(1));
        chk("rand_err_clear", RW'(err_timeout), '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/rtu_arbiter.md
RTU_ARBITER -- requirements
Module: rtu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one reverse transform unit (RTU).
REQ-002 Parameter DATA_W, default 40, signed element width of M and R tiles.
REQ-003 Parameter TIMEOUT, default 32, maximum cycles in RUN before error.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester tile-ready request, level.
REQ-007 m_tile  in  NUM_REQ x 6x6 x DATA_W  per-requester 6x6 M tile, valid while req high.
REQ-008 ack  out  NUM_REQ  one-cycle pulse: tile captured, requester may change m_tile/drop req.
REQ-009 r_tile  out  4x4 x DATA_W  transformed 4x4 result.
REQ-010 r_valid  out  1  r_tile/r_id valid.
REQ-011 r_id  out  clog2(NUM_REQ)  index of requester owning r_tile.
REQ-012 r_ready  in  1  consumer accepts result when r_valid and r_ready.
REQ-013 rtu_start  out  1  RTU start, level.
REQ-014 rtu_m  out  6x6 x DATA_W  RTU input tile, driven from internal m_buf.
REQ-015 rtu_r  in  4x4 x DATA_W  RTU result.
REQ-016 rtu_done  in  1  RTU done, level, held until rtu_start drops.
REQ-017 rtu_busy  in  1  RTU busy.
REQ-018 err_timeout  out  1  sticky: RTU did not finish within TIMEOUT cycles.

Function
REQ-019 States: IDLE, RUN, OUT; encoding per shared enum.
REQ-020 IDLE: when any req high and rtu_done==0 and rtu_busy==0, grant index g chosen round-robin starting at ptr; capture m_tile[g] into m_buf, latch r_id<=g, ack[g]<=1 for one cycle, rtu_start<=1, go RUN.
REQ-021 Round-robin: after grant, ptr<=(g+1) mod NUM_REQ; lowest index wins only relative to ptr.
REQ-022 IDLE with no req: outputs hold, ptr unchanged.
REQ-023 RUN: rtu_start held 1; wdog counter increments per cycle; when rtu_done==1 capture rtu_r into r_tile, rtu_start<=0, r_valid<=1, go OUT.
REQ-024 RUN: if wdog reaches TIMEOUT before rtu_done, set err_timeout, rtu_start<=0, go IDLE, no r_valid; ptr already advanced.
REQ-025 OUT: r_valid, r_tile, r_id stable until r_ready; on r_valid&&r_ready r_valid<=0, go IDLE.
REQ-026 No bypass: a grant occurs no earlier than the cycle after OUT exits, guaranteeing RTU has seen rtu_start low.
REQ-027 Latency with a 10-compute-cycle RTU: ack at cycle 1 after req sampled; r_valid at cycle 13; back-to-back throughput one tile per 14 cycles with r_ready tied high.
REQ-028 req dropped by a requester in the grant cycle is still granted (sampled value governs); req of other requesters during RUN/OUT is ignored until IDLE.
REQ-029 m_buf is the only source of rtu_m; changes to m_tile after ack do not affect the result.
REQ-030 Arithmetic: no modification of data; widths pass through at DATA_W.

Reset
REQ-031 On rst: state IDLE, ptr 0, ack 0, rtu_start 0, r_valid 0, r_id 0, r_tile 0, m_buf 0, wdog 0, err_timeout 0.
REQ-032 Reset mid-RUN or mid-OUT discards the in-flight tile with no ack or r_valid afterward; RTU reset is external and shall be asserted with rst by the integrator.
REQ-033 err_timeout cleared only by rst.

Structure
REQ-034 DATA_W, tile dimensions (6, 4) and the state enum shall live in winograd_pkg.
REQ-035 Round-robin selection shall be sub-module rr_arbiter (req, ptr in; grant index and any_req out; combinational).

Verification
REQ-036 Single req[2], M = identity-like tile with M[0][0]=5, others 0 -> ack[2] at cycle 1, r_valid at cycle 13, r_id=2, r_tile[0][0]=5, others 0.
REQ-037 All four req held high, r_ready=1 -> grants in order 0,1,2,3,0; each r_id matches; 14-cycle spacing.
REQ-038 r_ready held low 20 cycles in OUT -> r_tile/r_id stable, no new ack, rtu_start 0.
REQ-039 Stub RTU never asserting rtu_done -> err_timeout at RUN cycle 32, rtu_start drops, next req granted.
REQ-040 rst asserted at RUN cycle 5 -> all outputs zero immediately; after release, pending req[1] granted with ptr=0 priority.
REQ-041 m_tile[0] changed the cycle after ack[0] -> result computed from originally captured tile.
